pingpong_buffer_dp: RTL and testbench
=====================================

# pingpong_buffer_dp

Parametrised double-bank (ping-pong) frame buffer on a single clock, placed between the input pre-processing stream and the convolution engine's random-access read port. The write side takes a valid/ready byte stream and fills one bank. The read side randomly addresses the other bank. Bank swap is automatic, driven by frame-complete and reader-release events instead of an external toggle. Adds backpressure, partial-frame flush, per-bank length tracking and explicit bank-valid signalling.

## Interface
- DW, 8, data word width
- DP, 768, words per bank (≥2); local AW = $clog2(DP), LW = AW+1
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_din  in  DW  write data
- i_din_vld  in  1  write data valid
- o_din_rdy  out  1  write bank can accept; transfer when vld&&rdy
- i_wr_flush  in  1  close current write bank early (partial frame)
- o_frame_done  out  1  one-cycle pulse: a bank was closed (FULL)
- i_rd_en  in  1  read request at i_rd_addr
- i_rd_addr  in  AW  read address within read bank
- o_rd_dout  out  DW  read data
- o_rd_dout_vld  out  1  o_rd_dout valid
- o_rd_bank_vld  out  1  read bank holds a closed frame, readable
- o_rd_len  out  LW  valid words in read bank
- i_rd_release  in  1  pulse: reader finished, free read bank

## Operation
- Per-bank state: EMPTY, FILLING, FULL, READING. Pointers: wb (write bank), rb (read bank), wr_cnt (LW bits), len[2] (LW bits).
- Reset: both banks EMPTY, wb=rb=0, wr_cnt=0, len=0. Outputs: o_din_rdy=1, all other outputs 0. Memory contents are not cleared.
- o_din_rdy = bank[wb] ∈ {EMPTY, FILLING}. Decoded from state registers only; no combinational path from any input.
- Accepted write: mem[wb][wr_cnt] <= i_din, wr_cnt++, bank[wb] -> FILLING.
- Close condition: accepted write with wr_cnt==DP-1, or i_wr_flush with (wr_cnt>0 or an accepted write in the same cycle). A same-cycle write is included in the frame.
- On close: len[wb] <= final count, bank[wb] -> FULL, wr_cnt <= 0, wb toggles, o_frame_done=1 for one cycle.
- Flush with empty bank and no write: ignored, no pulse.
- Read side: bank[rb]==FULL -> READING on the next cycle. o_rd_bank_vld=1 iff bank[rb]==READING. o_rd_len = len[rb] while valid, else 0.
- i_rd_en with o_rd_bank_vld: o_rd_dout <= mem[rb][i_rd_addr], o_rd_dout_vld=1 next cycle. If i_rd_addr ≥ len[rb], o_rd_dout=0 (still vld). i_rd_en without bank valid: ignored, vld stays 0.
- i_rd_release while READING: bank[rb] -> EMPTY, rb toggles. Release in any other state is ignored.
- Read and release in the same cycle: the read completes with old rb data, then the bank is released.
- Close of wb and release of rb in the same cycle (different banks): both take effect.
- If wb toggles onto a bank that is FULL or READING: o_din_rdy=0 until that bank is released; rdy rises the cycle after the release.
- Overflow is impossible by construction. Data is never dropped while i_din_vld is held.

## Timing
- Write accept: same edge. Last word at edge t -> o_frame_done high in cycle t+1, bank FULL at t+1, o_rd_bank_vld high at t+2 (if rb points to it).
- Read latency: 1 cycle (registered output). Back-to-back reads, one per cycle.
- Release at edge t -> o_rd_bank_vld low at t+1. The next bank, if FULL, gives o_rd_bank_vld high at t+2.
- Async reset: outputs go to reset values immediately. Mid-operation reset discards all frames. First accept is possible on the first edge after deassertion.

## Structure
- Package pingpong_buf_pkg: bank_state_e enum (EMPTY/FILLING/FULL/READING), bank index type.
- Sub-module pp_bank_ram: DW×DP, one write port, synchronous read, one instance per bank. Write enable and read enable are gated by wb/rb; no clock muxing.
- Top-level: bank FSMs, counters, output mux/register.

## Test plan
- Reset: assert i_rst mid-cycle -> o_din_rdy=1, o_frame_done=o_rd_bank_vld=o_rd_dout_vld=0, o_rd_len=0.
- DP=8, write 1..8 continuously -> o_frame_done pulse the cycle after word 8; o_rd_bank_vld one cycle later with o_rd_len=8; reads of addr 0..7 return 1..8, each one cycle after request.
- No release, write 1..16 -> o_din_rdy=0 after word 16; pulse i_rd_release -> rdy=1 next cycle, new read bank gives o_rd_len=8 and data 9..16.
- Write 3 words, then flush in the same cycle as word 4 -> o_rd_len=4; read addr 3 -> 4; read addr 6 -> 0.
- Flush on an empty bank -> no o_frame_done; release without a valid bank -> no state change; read+release in the same cycle -> data returned, bank freed.
- Reset during fill of word 5 -> all flags clear; the following 8-word frame reads back correctly from bank 0.

Source files
------------

// File: rtl/pingpong_buf_pkg.sv
// Shared types for the ping-pong frame buffer.
// Bank lifecycle states and the bank index type.
package pingpong_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

    typedef logic bank_idx_t;

endpackage

// File: rtl/pp_bank_ram.sv
// One bank of the ping-pong buffer: single write port,
// synchronous registered read port, no reset on storage.
module pp_bank_ram
    import pingpong_buf_pkg::*;
#(
    parameter int DW = 8,
    parameter int DP = 768,
    parameter int AW = $clog2(DP)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem_q [DP];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/pingpong_buffer_dp.sv
// Double-bank frame buffer: streamed writes fill one bank while the
// reader randomly addresses the other; swaps on close and release.
module pingpong_buffer_dp
    import pingpong_buf_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int DP = 768,
    localparam int AW = $clog2(DP),
    localparam int LW = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_din,
    input  logic          i_din_vld,
    output logic          o_din_rdy,
    input  logic          i_wr_flush,
    output logic          o_frame_done,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_dout,
    output logic          o_rd_dout_vld,
    output logic          o_rd_bank_vld,
    output logic [LW-1:0] o_rd_len,
    input  logic          i_rd_release
);

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic [LW-1:0] len_q   [2];
    logic [LW-1:0] len_d   [2];
    bank_idx_t     wb_q, wb_d;
    bank_idx_t     rb_q, rb_d;
    logic [LW-1:0] wr_cnt_q, wr_cnt_d;
    logic          frame_done_q;
    logic          dout_vld_q;
    logic          oor_q;
    bank_idx_t     sel_q;

    logic          din_rdy;
    logic          wr_acc;
    logic          wr_close;
    logic [LW-1:0] wr_cnt_inc;
    logic          rd_vld;
    logic          rd_fire;
    logic          rd_inrange;
    logic          rel_fire;
    logic [DW-1:0] rdata [2];

    always_comb begin
        din_rdy    = (state_q[wb_q] == EMPTY) ||
                     (state_q[wb_q] == FILLING);
        wr_acc     = i_din_vld && din_rdy;
        wr_cnt_inc = wr_cnt_q + {{AW{1'b0}}, wr_acc};
        wr_close   = (wr_acc && (wr_cnt_q == LW'(DP - 1))) ||
                     (i_wr_flush && ((wr_cnt_q != '0) || wr_acc));
        rd_vld     = (state_q[rb_q] == READING);
        rd_fire    = i_rd_en && rd_vld;
        rd_inrange = ({1'b0, i_rd_addr} < len_q[rb_q]);
        rel_fire   = i_rd_release && rd_vld;
    end

    // Close and release always hit different banks, so per-bank
    // priority only has to order the write side before the read side.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            len_d[i]   = len_q[i];
            if (wr_close && (wb_q == bank_idx_t'(i))) begin
                state_d[i] = FULL;
                len_d[i]   = wr_cnt_inc;
            end else if (wr_acc && (wb_q == bank_idx_t'(i))) begin
                state_d[i] = FILLING;
            end else if (rb_q == bank_idx_t'(i)) begin
                if (state_q[i] == FULL) begin
                    state_d[i] = READING;
                end else if (rel_fire) begin
                    state_d[i] = EMPTY;
                end
            end
        end
        wb_d     = wr_close ? ~wb_q : wb_q;
        rb_d     = rel_fire ? ~rb_q : rb_q;
        wr_cnt_d = wr_close ? '0 : wr_cnt_inc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q[0]   <= EMPTY;
            state_q[1]   <= EMPTY;
            len_q[0]     <= '0;
            len_q[1]     <= '0;
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            wr_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            dout_vld_q   <= 1'b0;
            oor_q        <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            state_q[0]   <= state_d[0];
            state_q[1]   <= state_d[1];
            len_q[0]     <= len_d[0];
            len_q[1]     <= len_d[1];
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            wr_cnt_q     <= wr_cnt_d;
            frame_done_q <= wr_close;
            dout_vld_q   <= rd_fire;
            if (rd_fire) begin
                oor_q <= !rd_inrange;
                sel_q <= rb_q;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_ram #(
            .DW (DW),
            .DP (DP),
            .AW (AW)
        ) u_ram (
            .i_clk   (i_clk),
            .i_we    (wr_acc && (wb_q == bank_idx_t'(b))),
            .i_waddr (wr_cnt_q[AW-1:0]),
            .i_wdata (i_din),
            .i_re    (rd_fire && rd_inrange &&
                      (rb_q == bank_idx_t'(b))),
            .i_raddr (i_rd_addr),
            .o_rdata (rdata[b])
        );
    end

    // Bank select is captured at request time so a same-cycle
    // release cannot redirect the pending read.
    assign o_din_rdy     = din_rdy;
    assign o_frame_done  = frame_done_q;
    assign o_rd_bank_vld = rd_vld;
    assign o_rd_len      = rd_vld ? len_q[rb_q] : '0;
    assign o_rd_dout_vld = dout_vld_q;
    assign o_rd_dout     = (dout_vld_q && !oor_q) ? rdata[sel_q] : '0;

endmodule

// File: tb/tb_pingpong_buffer_dp.sv
// Scoreboard bench for pingpong_buffer_dp with DP=8.
module tb_pingpong_buffer_dp;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AW = $clog2(DP);
    localparam int LW = AW + 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_rdy;
    logic          wr_flush;
    logic          frame_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_dout;
    logic          rd_dout_vld;
    logic          rd_bank_vld;
    logic [LW-1:0] rd_len;
    logic          rd_release;

    int n_tests;
    int n_fail;
    int exp_q[$];

    pingpong_buffer_dp #(
        .DW (DW),
        .DP (DP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_din         (din),
        .i_din_vld     (din_vld),
        .o_din_rdy     (din_rdy),
        .i_wr_flush    (wr_flush),
        .o_frame_done  (frame_done),
        .i_rd_en       (rd_en),
        .i_rd_addr     (rd_addr),
        .o_rd_dout     (rd_dout),
        .o_rd_dout_vld (rd_dout_vld),
        .o_rd_bank_vld (rd_bank_vld),
        .o_rd_len      (rd_len),
        .i_rd_release  (rd_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input bit fl);
        din      = DW'(d);
        din_vld  = 1'b1;
        wr_flush = fl;
        tick();
        din_vld  = 1'b0;
        wr_flush = 1'b0;
    endtask

    task automatic rd(input int a, input int exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        exp_q.push_back(exp);
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic chk_flags(input string tag);
        check({tag, "_rdy"},  int'(din_rdy),     1);
        check({tag, "_done"}, int'(frame_done),  0);
        check({tag, "_bvld"}, int'(rd_bank_vld), 0);
        check({tag, "_dvld"}, int'(rd_dout_vld), 0);
        check({tag, "_len"},  int'(rd_len),      0);
    endtask

    always @(negedge clk) begin
        if (rd_dout_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexp_vld", 1, 0);
            end else begin
                check("rd_data", int'(rd_dout), exp_q.pop_front());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        din        = '0;
        din_vld    = 1'b0;
        wr_flush   = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_release = 1'b0;

        #2 rst = 1'b1;
        #1 chk_flags("rst");
        tick();
        tick();
        rst = 1'b0;

        for (int i = 1; i <= 8; i++) wr(i, 1'b0);
        check("f1_done", int'(frame_done), 1);
        check("f1_bvld_early", int'(rd_bank_vld), 0);
        check("f1_rdy", int'(din_rdy), 1);
        tick();
        check("f1_done_pulse", int'(frame_done), 0);
        check("f1_bvld", int'(rd_bank_vld), 1);
        check("f1_len", int'(rd_len), 8);
        for (int a = 0; a < 8; a++) rd(a, a + 1);
        tick();

        for (int i = 9; i <= 16; i++) wr(i, 1'b0);
        check("f2_done", int'(frame_done), 1);
        check("f2_rdy_block", int'(din_rdy), 0);
        din     = 8'd17;
        din_vld = 1'b1;
        tick();
        tick();
        check("f2_rdy_hold", int'(din_rdy), 0);
        check("f2_done_once", int'(frame_done), 0);
        din_vld    = 1'b0;
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check("f2_rdy_rel", int'(din_rdy), 1);
        check("f2_bvld_rel", int'(rd_bank_vld), 0);
        tick();
        check("f2_bvld", int'(rd_bank_vld), 1);
        check("f2_len", int'(rd_len), 8);
        for (int a = 0; a < 8; a++) rd(a, a + 9);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;

        wr(1, 1'b0);
        wr(2, 1'b0);
        wr(3, 1'b0);
        wr(4, 1'b1);
        check("f3_done", int'(frame_done), 1);
        tick();
        check("f3_bvld", int'(rd_bank_vld), 1);
        check("f3_len", int'(rd_len), 4);
        rd(3, 4);
        rd(6, 0);
        rd(0, 1);
        rd(4, 0);
        tick();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;

        wr_flush = 1'b1;
        tick();
        wr_flush = 1'b0;
        check("f4_flush_nop", int'(frame_done), 0);
        tick();
        check("f4_flush_nop2", int'(frame_done), 0);
        check("f4_bvld", int'(rd_bank_vld), 0);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check("f4_rel_rdy", int'(din_rdy), 1);
        check("f4_rel_bvld", int'(rd_bank_vld), 0);
        for (int i = 21; i <= 28; i++) wr(i, 1'b0);
        check("f4_done", int'(frame_done), 1);
        tick();
        check("f4_bvld2", int'(rd_bank_vld), 1);
        check("f4_len", int'(rd_len), 8);
        rd_release = 1'b1;
        rd(2, 23);
        rd_release = 1'b0;
        check("f4_rr_bvld", int'(rd_bank_vld), 0);
        check("f4_rr_rdy", int'(din_rdy), 1);
        tick();

        for (int i = 31; i <= 34; i++) wr(i, 1'b0);
        din     = 8'd35;
        din_vld = 1'b1;
        #2 rst = 1'b1;
        #1 chk_flags("mrst");
        din_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 41; i <= 48; i++) wr(i, 1'b0);
        check("f5_done", int'(frame_done), 1);
        tick();
        check("f5_bvld", int'(rd_bank_vld), 1);
        check("f5_len", int'(rd_len), 8);
        for (int a = 7; a >= 0; a--) rd(a, 41 + a);
        tick();
        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
